// File: rtl/float_add.sv
// ============================================================================
//  Module      : float_add
//  Description : IEEE-754 binary32 adder, one result per clock, registered
//                output one cycle after the operands are sampled.
//                Subnormal inputs and results are flushed to signed zero.
//                NaN in or +inf + -inf gives canonical quiet NaN 7FC00000.
//                Default rounding is truncation toward zero; defining the
//                macro FLOAT_ADD_RNE_EN selects round-to-nearest-even.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset, clears sum
//                X, Y - binary32 operands
//                sum  - registered binary32 result X+Y
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module float_add #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] X,
    input  logic [XLEN-1:0] Y,
    output logic [XLEN-1:0] sum
);

    localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

    // Leading-zero count of a 27-bit value; 27 when the value is zero.
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        n = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (v[i]) n = 5'(26 - i);
        end
        return n;
    endfunction

    // ---------------- unpack and classify ----------------
    logic [7:0]  w_xe, w_ye;
    logic [22:0] w_xf, w_yf;
    logic        w_xnan, w_ynan, w_xinf, w_yinf;

    assign w_xe   = X[30:23];
    assign w_ye   = Y[30:23];
    // Subnormals collapse to zero: with exp==0 the fraction is discarded.
    assign w_xf   = (w_xe == 8'd0) ? 23'd0 : X[22:0];
    assign w_yf   = (w_ye == 8'd0) ? 23'd0 : Y[22:0];
    assign w_xnan = (&w_xe) &  (|X[22:0]);
    assign w_ynan = (&w_ye) &  (|Y[22:0]);
    assign w_xinf = (&w_xe) & ~(|X[22:0]);
    assign w_yinf = (&w_ye) & ~(|Y[22:0]);

    // ---------------- order by magnitude ----------------
    logic        w_swap;
    logic        w_bs;
    logic [7:0]  w_be, w_se;
    logic [23:0] w_bm, w_sm;

    assign w_swap = {w_ye, w_yf} > {w_xe, w_xf};
    assign w_bs   = w_swap ? Y[31] : X[31];
    assign w_be   = w_swap ? w_ye : w_xe;
    assign w_se   = w_swap ? w_xe : w_ye;
    assign w_bm   = w_swap ? {|w_ye, w_yf} : {|w_xe, w_xf};
    assign w_sm   = w_swap ? {|w_xe, w_xf} : {|w_ye, w_yf};

    // ---------------- align smaller significand ----------------
    // 27 bits = 24-bit significand plus guard, round, sticky. Shifting a
    // 54-bit window lets everything shifted past bit 0 fold into sticky.
    logic [7:0]  w_diff;
    logic [4:0]  w_shamt;
    logic [53:0] w_wide;
    logic [26:0] w_bext, w_sal;

    assign w_diff  = w_be - w_se;
    assign w_shamt = (w_diff > 8'd27) ? 5'd27 : w_diff[4:0];
    assign w_wide  = {w_sm, 3'b000, 27'd0} >> w_shamt;
    assign w_sal   = {w_wide[53:28], w_wide[27] | (|w_wide[26:0])};
    assign w_bext  = {w_bm, 3'b000};

    // ---------------- add / subtract ----------------
    logic        w_sub;
    logic [27:0] w_raw;

    assign w_sub = X[31] ^ Y[31];
    // Magnitude ordering guarantees the difference is non-negative.
    assign w_raw = w_sub ? ({1'b0, w_bext} - {1'b0, w_sal})
                         : ({1'b0, w_bext} + {1'b0, w_sal});

    // ---------------- normalize ----------------
    logic [4:0]        w_lz;
    logic [26:0]       w_norm;
    logic signed [9:0] w_e1;

    assign w_lz = lzc27(w_raw[26:0]);

    always_comb begin
        w_norm = w_raw[26:0] << w_lz;
        w_e1   = $signed({2'b00, w_be}) - $signed({5'd0, w_lz});
        if (w_raw[27]) begin
            // Carry out: shift right one, keeping the dropped bit as sticky.
            w_norm = {w_raw[27:2], w_raw[1] | w_raw[0]};
            w_e1   = $signed({2'b00, w_be}) + 10'sd1;
        end
    end

    // ---------------- round ----------------
    logic [22:0]       w_frac;
    logic signed [9:0] w_e2;

`ifdef FLOAT_ADD_RNE_EN
    logic        w_rup;
    logic [24:0] w_mr;

    assign w_rup  = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_mr   = {1'b0, w_norm[26:3]} + {24'd0, w_rup};
    // Rounding 1.FFFFFF up yields 10.000000: renormalize.
    assign w_frac = w_mr[24] ? w_mr[23:1] : w_mr[22:0];
    assign w_e2   = w_mr[24] ? (w_e1 + 10'sd1) : w_e1;
`else
    logic w_unused;

    assign w_frac   = w_norm[25:3];
    assign w_e2     = w_e1;
    assign w_unused = &{1'b0, w_norm[26], w_norm[2:0]};
`endif

    // ---------------- result select ----------------
    logic [31:0] w_res;

    always_comb begin
        w_res = {w_bs, w_e2[7:0], w_frac};
        if (w_xnan || w_ynan || (w_xinf && w_yinf && w_sub)) begin
            w_res = C_QNAN;
        end else if (w_xinf) begin
            w_res = X;
        end else if (w_yinf) begin
            w_res = Y;
        end else if (w_raw == 28'd0) begin
            // Exact cancellation is +0; only -0 + -0 keeps the minus sign.
            w_res = {w_bs & ~w_sub, 31'd0};
        end else if (w_e1 <= 10'sd0) begin
            w_res = {w_bs, 31'd0};
        end else if (w_e2 >= 10'sd255) begin
            w_res = {w_bs, 8'hFF, 23'd0};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sum <= '0;
        end else begin
            sum <= w_res;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_float_add.sv
`default_nettype none

module tb_float_add;

    logic        clk;
    logic        rst;
    logic [31:0] X;
    logic [31:0] Y;
    logic [31:0] sum;

    int n_vec;
    int n_err;

    float_add #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .X  (X),
        .Y  (Y),
        .sum(sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: exact integer arithmetic on operands scaled by 2^149, then
    // rounded to 24 significant bits in the selected mode.
    function automatic logic [31:0] ref_add(input logic [31:0] a, input logic [31:0] b);
        logic [299:0] va, vb, mag, one, mask;
        logic         sg, half, rest;
        logic [7:0]   ea, eb;
        logic [23:0]  mant;
        int           p, e;
        ea = a[30:23];
        eb = b[30:23];
        if ((ea == 8'hFF && a[22:0] != 0) || (eb == 8'hFF && b[22:0] != 0))
            return 32'h7FC00000;
        if (ea == 8'hFF && eb == 8'hFF)
            return (a[31] != b[31]) ? 32'h7FC00000 : a;
        if (ea == 8'hFF) return a;
        if (eb == 8'hFF) return b;
        va = '0;
        vb = '0;
        if (ea != 0) va = {276'd0, 1'b1, a[22:0]} << (ea - 1);
        if (eb != 0) vb = {276'd0, 1'b1, b[22:0]} << (eb - 1);
        if (a[31] == b[31]) begin
            mag = va + vb; sg = a[31];
        end else if (va > vb) begin
            mag = va - vb; sg = a[31];
        end else if (vb > va) begin
            mag = vb - va; sg = b[31];
        end else begin
            return 32'h00000000;
        end
        if (mag == 0) return {sg, 31'd0};
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        e = p - 22;
        if (e <= 0) return {sg, 31'd0};
        mant = 24'(mag >> (p - 23));
        half = 1'b0;
        rest = 1'b0;
        if (p >= 24) begin
            half = mag[p - 24];
            one  = 300'd1;
            mask = (one << (p - 24)) - one;
            rest = |(mag & mask);
        end
`ifdef FLOAT_ADD_RNE_EN
        if (half && (rest || mant[0])) begin
            if (mant == 24'hFFFFFF) begin
                mant = 24'h800000;
                e    = e + 1;
            end else begin
                mant = mant + 1;
            end
        end
`else
        if (half || rest) mant = mant;
`endif
        if (e >= 255) return {sg, 8'hFF, 23'd0};
        return {sg, 8'(e), mant[22:0]};
    endfunction

    function automatic logic [31:0] rand_op();
        logic [31:0] r;
        int          m;
        r = $urandom;
        m = $urandom_range(0, 19);
        case (m)
            0:       r[30:0] = 31'd0;
            1:       r[30:23] = 8'd0;
            2:       r[30:23] = 8'hFF;
            3:       r[30:23] = 8'(8'd245 + 8'($urandom_range(0, 9)));
            4:       r[30:23] = 8'($urandom_range(1, 6));
            default: r[30:23] = 8'($urandom_range(110, 145));
        endcase
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        X   = 32'h3F800000;
        Y   = 32'h3F800000;
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++;
            if (sum !== 32'h00000000) begin
                n_err++;
                $display("FAIL reset cycle %0d: sum=%h expected=%h", i, sum, 32'h0);
            end
        end
        rst = 1'b0;
        step();
        n_vec++;
        if (sum !== 32'h40000000) begin
            n_err++;
            $display("FAIL reset_release: sum=%h expected=%h", sum, 32'h40000000);
        end
    endtask

    task automatic test_same_sign();
        logic [31:0] xs[3] = '{32'h404CCCCC, 32'h3FC00000, 32'hBF000000};
        logic [31:0] ys[3] = '{32'h40866666, 32'h3FC00000, 32'hC0CCCCCC};
        logic [31:0] es[3] = '{32'h40ECCCCC, 32'h40400000, 32'hC0DCCCCC};
        for (int i = 0; i < 3; i++) begin
            X = xs[i];
            Y = ys[i];
            step();
            n_vec++;
            if (sum !== es[i]) begin
                n_err++;
                $display("FAIL same_sign %h+%h: sum=%h expected=%h", xs[i], ys[i], sum, es[i]);
            end
        end
    endtask

    task automatic test_mixed_sign();
        logic [31:0] xs[4] = '{32'hBF000000, 32'h3F800000, 32'h41200000, 32'h4034B4B5};
        logic [31:0] ys[4] = '{32'h40CCCCCC, 32'hBF800000, 32'hC1200000, 32'hBF70F0F1};
        logic [31:0] es[4] = '{32'h40BCCCCC, 32'h00000000, 32'h00000000, 32'h0};
        es[3] = ref_add(xs[3], ys[3]);
        for (int i = 0; i < 4; i++) begin
            X = xs[i];
            Y = ys[i];
            step();
            n_vec++;
            if (sum !== es[i]) begin
                n_err++;
                $display("FAIL mixed_sign %h+%h: sum=%h expected=%h", xs[i], ys[i], sum, es[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] xs[8], ys[8];
        for (int i = 0; i < 8; i++) begin
            xs[i] = rand_op();
            ys[i] = rand_op();
        end
        X = xs[0];
        Y = ys[0];
        for (int i = 0; i < 8; i++) begin
            step();
            n_vec++;
            if (sum !== ref_add(xs[i], ys[i])) begin
                n_err++;
                $display("FAIL back_to_back[%0d] %h+%h: sum=%h expected=%h",
                         i, xs[i], ys[i], sum, ref_add(xs[i], ys[i]));
            end
            if (i < 7) begin
                X = xs[i + 1];
                Y = ys[i + 1];
            end
        end
    endtask

    task automatic test_specials();
        logic [31:0] xs[10] = '{32'h7F800000, 32'h7F7FFFFF, 32'h00000001, 32'h7FC00000,
                                32'h80000000, 32'h00000000, 32'h00000000, 32'hFF800000,
                                32'h7F800000, 32'h4B800000};
        logic [31:0] ys[10] = '{32'hFF800000, 32'h7F7FFFFF, 32'h3F800000, 32'h3F800000,
                                32'h80000000, 32'h80000000, 32'hC1234567, 32'h42000000,
                                32'h7F800000, 32'h33800000};
        logic [31:0] es[10] = '{32'h7FC00000, 32'h7F800000, 32'h3F800000, 32'h7FC00000,
                                32'h80000000, 32'h00000000, 32'hC1234567, 32'hFF800000,
                                32'h7F800000, 32'h4B800000};
        for (int i = 0; i < 10; i++) begin
            X = xs[i];
            Y = ys[i];
            step();
            n_vec++;
            if (sum !== es[i]) begin
                n_err++;
                $display("FAIL special %h+%h: sum=%h expected=%h", xs[i], ys[i], sum, es[i]);
            end
        end
    endtask

    task automatic test_commutativity();
        logic [31:0] a, b, s1, exp_s;
        for (int i = 0; i < 300; i++) begin
            a = rand_op();
            b = rand_op();
            if (i % 3 == 0) b[30:23] = 8'(a[30:23] - 8'($urandom_range(0, 30)));
            exp_s = ref_add(a, b);
            X = a;
            Y = b;
            step();
            s1 = sum;
            n_vec++;
            if (s1 !== exp_s) begin
                n_err++;
                $display("FAIL model %h+%h: sum=%h expected=%h", a, b, s1, exp_s);
            end
            X = b;
            Y = a;
            step();
            n_vec++;
            if (sum !== s1) begin
                n_err++;
                $display("FAIL commute %h+%h: swapped sum=%h expected=%h", a, b, sum, s1);
            end
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        X     = '0;
        Y     = '0;
        test_reset();
        test_same_sign();
        test_mixed_sign();
        test_back_to_back();
        test_specials();
        test_commutativity();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
